// File: rtl/sici_pcs_pkg.sv
// Constants and helpers shared by the SICI PCS receive path (gearbox and frame synchroniser).
package sici_pcs_pkg;

  localparam int SICI_IW = 32;
  localparam int SICI_FW = 96;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/sici_pcs_gearbox.sv
// Receive gearbox: packs IW-bit words into FW-bit frames with a one-bit slip for sync hunting.
// Optional slip statistics counter enabled by defining SICI_GBX_STAT_EN.
module sici_pcs_gearbox
  import sici_pcs_pkg::*;
#(
  parameter int IW = SICI_IW,
  parameter int FW = SICI_FW
) (
  input  logic          Ck,
  input  logic          Rs,
  input  logic          In_Vld,
  input  logic [IW-1:0] In_Dat,
  input  logic          Bit_Slp,
  output logic          Out_Vld,
  output logic [FW-1:0] Out_Dat
`ifdef SICI_GBX_STAT_EN
  ,
  output logic [15:0]   Slp_Cnt
`endif
);

  localparam int BW = FW + IW;
  localparam int CW = clog2(BW + 1);
  localparam logic [CW-1:0] FW_C  = CW'(FW);
  localparam logic [CW-1:0] IW_C  = CW'(IW);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  // Oldest bit sits at the MSB; bits below the valid count are always zero.
  logic [BW-1:0] sreg;
  logic [CW-1:0] cnt;
  logic          pend;

  logic          emit;
  logic          req;
  logic          slip_x;
  logic [CW-1:0] rem;
  logic [CW-1:0] cnt_rem;
  logic [CW-1:0] cnt_nxt;
  logic [BW-1:0] kept;
  logic [BW-1:0] word_al;
  logic [BW-1:0] sreg_nxt;

  always_comb begin
    emit     = (cnt >= FW_C);
    req      = pend | Bit_Slp;
    slip_x   = req & ~emit & (cnt != '0);
    rem      = emit ? FW_C : (slip_x ? ONE_C : '0);
    kept     = sreg << rem;
    cnt_rem  = cnt - rem;
    // New word lands directly behind whatever survives this cycle's removal.
    word_al  = {In_Dat, {FW{1'b0}}} >> cnt_rem;
    sreg_nxt = In_Vld ? (kept | word_al) : kept;
    cnt_nxt  = In_Vld ? (cnt_rem + IW_C) : cnt_rem;
  end

  always_ff @(posedge Ck) begin
    if (Rs) begin
      sreg    <= '0;
      cnt     <= '0;
      pend    <= 1'b0;
      Out_Vld <= 1'b0;
      Out_Dat <= '0;
    end else begin
      sreg    <= sreg_nxt;
      cnt     <= cnt_nxt;
      pend    <= req & ~slip_x;
      Out_Vld <= emit;
      if (emit) Out_Dat <= sreg[BW-1 -: FW];
    end
  end

`ifdef SICI_GBX_STAT_EN
  always_ff @(posedge Ck) begin
    if (Rs)
      Slp_Cnt <= '0;
    else if (slip_x && (Slp_Cnt != 16'hFFFF))
      Slp_Cnt <= Slp_Cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_sici_pcs_gearbox.sv
// Self-checking bench for sici_pcs_gearbox: bit-queue reference model feeding a frame scoreboard.
module tb_sici_pcs_gearbox;

  localparam int IW = 32;
  localparam int FW = 96;

  logic          Ck;
  logic          Rs;
  logic          In_Vld;
  logic [IW-1:0] In_Dat;
  logic          Bit_Slp;
  logic          Out_Vld;
  logic [FW-1:0] Out_Dat;
`ifdef SICI_GBX_STAT_EN
  logic [15:0]   Slp_Cnt;
`endif

  sici_pcs_gearbox #(.IW(IW), .FW(FW)) dut (
    .Ck      (Ck),
    .Rs      (Rs),
    .In_Vld  (In_Vld),
    .In_Dat  (In_Dat),
    .Bit_Slp (Bit_Slp),
    .Out_Vld (Out_Vld),
    .Out_Dat (Out_Dat)
`ifdef SICI_GBX_STAT_EN
    ,
    .Slp_Cnt (Slp_Cnt)
`endif
  );

  initial Ck = 1'b0;
  always #5 Ck = ~Ck;

  int passed = 0;
  int total  = 0;

  // Reference model: received bits in arrival order, earliest at index 0.
  bit            mq[$];
  bit            mpend;
  int            mslips;
  logic [FW-1:0] sb[$];
  logic [FW-1:0] exp_dat;
  int            nvld;

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  task automatic do_reset(input logic vld, input logic [IW-1:0] dat, input logic slp);
    Rs = 1'b1; In_Vld = vld; In_Dat = dat; Bit_Slp = slp;
    mq.delete(); sb.delete();
    mpend = 1'b0; mslips = 0; exp_dat = '0;
    @(posedge Ck); #1;
    Rs = 1'b0; In_Vld = 1'b0; Bit_Slp = 1'b0;
    chk("rst_vld", FW'(Out_Vld), '0);
    chk("rst_dat", Out_Dat, '0);
`ifdef SICI_GBX_STAT_EN
    chk("rst_slpcnt", FW'(Slp_Cnt), '0);
`endif
  endtask

  task automatic step(input logic vld, input logic [IW-1:0] dat, input logic slp);
    bit            emit, req, sx;
    logic [FW-1:0] fr;
    In_Vld = vld; In_Dat = dat; Bit_Slp = slp;
    emit = (mq.size() >= FW);
    req  = mpend || slp;
    sx   = req && !emit && (mq.size() >= 1);
    if (emit) begin
      for (int i = 0; i < FW; i++) fr[FW-1-i] = mq[i];
      for (int i = 0; i < FW; i++) void'(mq.pop_front());
      sb.push_back(fr);
    end else if (sx) begin
      void'(mq.pop_front());
      mslips++;
    end
    mpend = req && !sx;
    if (vld) for (int i = IW-1; i >= 0; i--) mq.push_back(dat[i]);
    @(posedge Ck); #1;
    In_Vld = 1'b0; Bit_Slp = 1'b0;
    chk("out_vld", FW'(Out_Vld), FW'(emit));
    if (Out_Vld) nvld++;
    if (emit && sb.size() > 0) exp_dat = sb.pop_front();
    chk("out_dat", Out_Dat, exp_dat);
`ifdef SICI_GBX_STAT_EN
    chk("slp_cnt", FW'(Slp_Cnt), FW'(mslips));
`endif
  endtask

  initial begin
    logic [FW-1:0] t1_exp;
    int            n0;
    t1_exp = 96'hA0000001_22222222_33333333;
    Rs = 1'b0; In_Vld = 1'b0; In_Dat = '0; Bit_Slp = 1'b0;
    nvld = 0;

    // Basic three-word frame with reset colliding with input and slip
    do_reset(1'b1, 32'hFFFFFFFF, 1'b1);
    step(1'b1, 32'hA0000001, 1'b0);
    step(1'b1, 32'h22222222, 1'b0);
    step(1'b1, 32'h33333333, 1'b0);
    step(1'b0, '0, 1'b0);
    chk("t1_frame", Out_Dat, t1_exp);
    chk("t1_vld", FW'(Out_Vld), FW'(1));
    step(1'b0, '0, 1'b0);

    // Continuous stream: 300 frames
    n0 = nvld;
    for (int i = 0; i < 900; i++) step(1'b1, $urandom, 1'b0);
    step(1'b0, '0, 1'b0);
    chk("cont_frames", FW'(nvld - n0), FW'(300));

    // Single slip with Cnt=32, then stream
    do_reset(1'b0, '0, 1'b0);
    step(1'b1, $urandom, 1'b0);
    step(1'b1, $urandom, 1'b1);
    for (int i = 0; i < 30; i++) step(1'b1, $urandom, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
    chk("slip1_count", FW'(mslips), FW'(1));

    // Three slip requests at Cnt=0 merge into one
    do_reset(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b1, $urandom, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
    chk("slip0_count", FW'(mslips), FW'(1));

    // Gapped input: one word every 4 cycles
    do_reset(1'b0, '0, 1'b0);
    n0 = nvld;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, $urandom, 1'b0);
      for (int j = 0; j < 3; j++) step(1'b0, '0, 1'b0);
    end
    chk("gap_frames", FW'(nvld - n0), FW'(4));

    // Reset mid-frame (Cnt=64) with slip asserted
    do_reset(1'b0, '0, 1'b0);
    step(1'b1, 32'hDEADBEEF, 1'b0);
    step(1'b1, 32'hCAFEF00D, 1'b0);
    do_reset(1'b1, 32'h12345678, 1'b1);
    step(1'b1, 32'h11111111, 1'b0);
    step(1'b1, 32'h44444444, 1'b0);
    step(1'b1, 32'h55555555, 1'b0);
    step(1'b0, '0, 1'b0);
    chk("rst_mid_frame", Out_Dat, 96'h11111111_44444444_55555555);
    step(1'b0, '0, 1'b0);

    chk("sb_empty", FW'(sb.size()), '0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
